// File: rtl/irrigation_sequencer.sv
// irrigation_sequencer
//   Two-zone watering sequencer. A start pulse opens zone A for its preset
//   time, waits GAP_TICKS ticks of dead time, opens zone B for its preset
//   time, then emits a one-cycle done pulse. The countdown is kept directly
//   in BCD (mm:ss) so the digits can feed a display mux without conversion.
//
// Ports
//   clk          system clock, rising-edge active
//   reset        asynchronous, active-high reset
//   tick         one-cycle 1 Hz strobe
//   start        one-cycle pulse, begins a cycle from IDLE
//   stop         one-cycle pulse, aborts to IDLE (no done pulse)
//   pause        one-cycle pulse, toggles pause in RUN_A/RUN_B/GAP
//   moisture_ok  level, ends the running zone early
//   dur_a, dur_b BCD presets {DM,UM,DS,US}
//   valve_a/b    registered valve drives
//   busy         high whenever not IDLE
//   done         one-cycle completion pulse
//   state        current FSM encoding
//   us/ds/um/dm  BCD countdown digits
module irrigation_sequencer #(
  parameter int GAP_TICKS = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        pause,
  input  logic        moisture_ok,
  input  logic [15:0] dur_a,
  input  logic [15:0] dur_b,
  output logic        valve_a,
  output logic        valve_b,
  output logic        busy,
  output logic        done,
  output logic [2:0]  state,
  output logic [3:0]  us,
  output logic [3:0]  ds,
  output logic [3:0]  um,
  output logic [3:0]  dm
);

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    RUN_A  = 3'd2,
    GAP    = 3'd3,
    LOAD_B = 3'd4,
    RUN_B  = 3'd5,
    PAUSE  = 3'd6,
    DONE   = 3'd7
  } state_t;

  state_t      st_reg, st_next;
  state_t      saved_reg, saved_next;
  logic [15:0] cnt_reg, cnt_next;   // {dm, um, ds, us}
  logic [3:0]  gap_reg, gap_next;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? max : d;
  endfunction

  // Tens digits saturate at 5, units digits at 9, giving at most 59:59.
  function automatic logic [15:0] clamp_preset(input logic [15:0] p);
    return {clamp_digit(p[15:12], 4'd5), clamp_digit(p[11:8], 4'd9),
            clamp_digit(p[7:4], 4'd5), clamp_digit(p[3:0], 4'd9)};
  endfunction

  // mm:ss BCD decrement; only called with a non-zero count.
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [3:0] d0, d1, d2, d3;
    {d3, d2, d1, d0} = c;
    if (d0 != 4'd0) d0 = d0 - 4'd1;
    else begin
      d0 = 4'd9;
      if (d1 != 4'd0) d1 = d1 - 4'd1;
      else begin
        d1 = 4'd5;
        if (d2 != 4'd0) d2 = d2 - 4'd1;
        else begin
          d2 = 4'd9;
          d3 = d3 - 4'd1;
        end
      end
    end
    return {d3, d2, d1, d0};
  endfunction

  // Input priority is stop > pause > moisture_ok > tick.
  always_comb begin
    st_next    = st_reg;
    cnt_next   = cnt_reg;
    gap_next   = gap_reg;
    saved_next = saved_reg;
    if (stop && st_reg != IDLE) begin
      st_next    = IDLE;
      cnt_next   = 16'h0000;
      gap_next   = 4'd0;
      saved_next = IDLE;
    end else begin
      case (st_reg)
        IDLE:   if (start) st_next = LOAD_A;
        LOAD_A: begin
          cnt_next = clamp_preset(dur_a);
          st_next  = RUN_A;
        end
        RUN_A, RUN_B: begin
          if (pause) begin
            saved_next = st_reg;
            st_next    = PAUSE;
          end else if (cnt_reg == 16'h0000 || moisture_ok) begin
            // Exit does not wait for a tick; a wet-soil exit also clears the count.
            cnt_next = 16'h0000;
            gap_next = 4'd0;
            st_next  = (st_reg == RUN_A) ? GAP : DONE;
          end else if (tick) begin
            cnt_next = bcd_dec(cnt_reg);
          end
        end
        GAP: begin
          if (pause) begin
            saved_next = st_reg;
            st_next    = PAUSE;
          end else if (gap_reg == 4'(GAP_TICKS)) begin
            st_next = LOAD_B;
          end else if (tick) begin
            gap_next = gap_reg + 4'd1;
          end
        end
        LOAD_B: begin
          cnt_next = clamp_preset(dur_b);
          st_next  = RUN_B;
        end
        PAUSE:  if (pause) st_next = saved_reg;
        DONE:   st_next = IDLE;
        default: st_next = IDLE;
      endcase
    end
  end

  // Outputs are registered from the state being entered so they line up with state.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      st_reg    <= IDLE;
      saved_reg <= IDLE;
      cnt_reg   <= 16'h0000;
      gap_reg   <= 4'd0;
      valve_a   <= 1'b0;
      valve_b   <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      st_reg    <= st_next;
      saved_reg <= saved_next;
      cnt_reg   <= cnt_next;
      gap_reg   <= gap_next;
      valve_a   <= (st_next == RUN_A);
      valve_b   <= (st_next == RUN_B);
      busy      <= (st_next != IDLE);
      done      <= (st_next == DONE);
    end
  end

  assign state = st_reg;
  assign dm    = cnt_reg[15:12];
  assign um    = cnt_reg[11:8];
  assign ds    = cnt_reg[7:4];
  assign us    = cnt_reg[3:0];

endmodule

// File: doc/irrigation_sequencer.md
IRRIGATION_SEQUENCER -- requirements
Module: irrigation_sequencer

Interface
REQ-001 SHALL have parameter GAP_TICKS, default 2, giving the dead time in ticks between zone A and zone B (range 0..15).
REQ-002 SHALL have port clk  in  1  system clock; all state changes on its rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have port tick  in  1  one-cycle 1 Hz strobe, synchronous to clk.
REQ-005 SHALL have port start  in  1  one-cycle pulse that begins a watering cycle.
REQ-006 SHALL have port stop  in  1  one-cycle pulse that aborts the cycle.
REQ-007 SHALL have port pause  in  1  one-cycle pulse that toggles pause.
REQ-008 SHALL have port moisture_ok  in  1  level; soil wet, end current zone early.
REQ-009 SHALL have ports dur_a, dur_b  in  16 each  BCD preset {DM,UM,DS,US}, one nibble per digit, US in [3:0].
REQ-010 SHALL have ports valve_a, valve_b  out  1 each  zone valve drive.
REQ-011 SHALL have port busy  out  1  high in any state except IDLE.
REQ-012 SHALL have port done  out  1  one-cycle completion pulse.
REQ-013 SHALL have port state  out  3  current FSM encoding.
REQ-014 SHALL have ports us, ds, um, dm  out  4 each  BCD countdown digits for the display mux.

Function
REQ-015 SHALL implement states IDLE=0, LOAD_A=1, RUN_A=2, GAP=3, LOAD_B=4, RUN_B=5, PAUSE=6, DONE=7.
REQ-016 SHALL move IDLE->LOAD_A on start; start SHALL be ignored in every other state.
REQ-017 SHALL, in LOAD_x, load the counter from dur_x in one cycle: a digit >9 loads as 9, a DS or DM digit >5 loads as 5.
REQ-018 SHALL go LOAD_A->RUN_A and LOAD_B->RUN_B on the next cycle.
REQ-019 SHALL, in RUN_x, decrement the counter once per tick: US 0->9 borrows DS; DS 0->5 borrows UM; UM 0->9 borrows DM.
REQ-020 SHALL leave RUN_x on the first cycle the counter reads 00:00, without waiting for a tick; a zero preset therefore gives one RUN cycle with no tick consumed.
REQ-021 SHALL drive valve_a only in RUN_A and valve_b only in RUN_B, both registered; the valve is on for exactly N ticks for preset N seconds.
REQ-022 SHALL, on leaving RUN_A, enter GAP, count GAP_TICKS ticks, then enter LOAD_B; GAP_TICKS=0 SHALL give a one-cycle GAP.
REQ-023 SHALL, on leaving RUN_B, enter DONE, assert done for that one cycle, then go to IDLE.
REQ-024 SHALL, when moisture_ok is high in RUN_x, exit as if the counter had reached 00:00.
REQ-025 SHALL apply input priority stop > pause > moisture_ok > tick within any cycle.
REQ-026 SHALL, on stop in any non-IDLE state, go to IDLE next cycle with valves off, counter cleared, and no done pulse.
REQ-027 SHALL, on pause in RUN_x or GAP, save the state, go to PAUSE, turn valves off, and hold the counter and GAP count.
REQ-028 SHALL, on pause in PAUSE, return to the saved state with the count unchanged; ticks in PAUSE SHALL be ignored; pause in IDLE, LOAD_x or DONE SHALL be ignored.
REQ-029 SHALL drive us/ds/um/dm from the counter in all states; the counter reads 00:00 in IDLE.

Reset
REQ-030 SHALL, on reset assertion at any time, immediately force state=IDLE, valves=0, busy=0, done=0, counter=00:00, GAP count=0, saved state=IDLE.
REQ-031 SHALL resume operation on the first clk edge after reset deasserts; a start coincident with that edge is accepted.

Verification
REQ-032 SHALL cover: dur_a=0x0003, dur_b=0x0002, GAP_TICKS=2 -> valve_a high for 3 ticks, 2-tick gap, valve_b high for 2 ticks, one done pulse, back in IDLE.
REQ-033 SHALL cover: dur_a=0x0100 -> after the first tick digits read 0,0:5,9; after 60 ticks RUN_A exits.
REQ-034 SHALL cover: pause mid RUN_A at 00:05, 10 ticks, pause again -> digits stay 00:05, valve_a low while paused, 5 more ticks to finish.
REQ-035 SHALL cover: stop and tick in the same cycle during RUN_B -> IDLE next cycle, valve_b=0, done never asserted.
REQ-036 SHALL cover: dur_a=0x0000, moisture_ok high during RUN_B, dur_a=0x00FF -> zone A skipped (valve_a pulses one cycle max, no tick used), zone B ends immediately, clamped preset loads as 00:59.
REQ-037 SHALL cover: reset asserted asynchronously mid-GAP -> all outputs 0 before the next clk edge.
